block_decryptor: RTL and testbench

//  Iterative 128-bit block decryptor. Inverts the team's encryptor round
//  s <- rotl(s ^ rk_i, ROT) by running its rounds in reverse order.

---
 rtl/block_decryptor_if.sv | 20 ++
 rtl/block_decryptor.sv | 96 +++++++++
 tb/tb_block_decryptor.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/block_decryptor_if.sv
// Bundles the start/busy/done handshake, the input block/key and the result
// of the block decryptor. The master drives requests; the slave is the core.
interface block_decryptor_if;
  logic         i_start;
  logic [127:0] i_ciphertext;
  logic [127:0] i_key;
  logic [127:0] o_plaintext;
  logic         o_done;
  logic         o_busy;

  modport master (
    output i_start, i_ciphertext, i_key,
    input  o_plaintext, o_done, o_busy
  );

  modport slave (
    input  i_start, i_ciphertext, i_key,
    output o_plaintext, o_done, o_busy
  );
endinterface

// File: rtl/block_decryptor.sv
// Iterative 128-bit block decryptor. Undoes the encryptor round
// s <- rotl(s ^ rk_i, ROT) by walking the key schedule backwards, one round
// per clock: s <- rotr(s, ROT) ^ rk_i for i = ROUNDS-1 down to 0.
module block_decryptor #(
  parameter int ROUNDS  = 16,
  parameter int ROT     = 8,
  parameter int KEY_ROT = 8
) (
  input logic              clk,
  input logic              rst,
  block_decryptor_if.slave bus
);

  // Counter only has to hold ROUNDS-1, so it can never wrap inside a block
  localparam int CW        = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  // Round key used first when decrypting is the last one the encryptor used
  localparam int LOAD_KROT = (KEY_ROT * (ROUNDS - 1)) % 128;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [CW-1:0] r_cnt;
  logic [127:0]  r_s;
  logic [127:0]  r_rk;
  logic [127:0]  r_plaintext;
  logic [127:0]  w_roundOut;
  logic          w_load;
  logic          w_last;

  function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
    int m;
    m = n % 128;
    if (m == 0) return x;
    return (x << m) | (x >> (128 - m));
  endfunction

  function automatic logic [127:0] rotr(input logic [127:0] x, input int n);
    return rotl(x, (128 - (n % 128)) % 128);
  endfunction

  assign w_roundOut = rotr(r_s, ROT) ^ r_rk;

  // Next-state decode: accept a start only when idle, leave RUN after round 0
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_load      = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (r_cnt == '0) begin
          w_last      = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State, round datapath and result register; result only moves on the final round
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_s         <= '0;
      r_rk        <= '0;
      r_plaintext <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_load) begin
        r_s   <= bus.i_ciphertext;
        r_rk  <= rotl(bus.i_key, LOAD_KROT);
        r_cnt <= CW'(ROUNDS - 1);
      end else if (r_state == RUN) begin
        r_s  <= w_roundOut;
        r_rk <= rotr(r_rk, KEY_ROT);
        if (w_last) begin
          r_plaintext <= w_roundOut;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign bus.o_plaintext = r_plaintext;
  assign bus.o_done      = (r_state == IDLE);
  assign bus.o_busy      = (r_state == RUN);

endmodule

// File: tb/tb_block_decryptor.sv
// Testbench for block_decryptor: a default 16-round instance (A) and a
// single-round instance (B). Expected plaintexts go into per-instance queues
// when a block is issued; monitors pop and compare on each rising done.
module tb_block_decryptor;

  logic clk;
  logic rst;

  block_decryptor_if ifA ();
  block_decryptor_if ifB ();

  block_decryptor #(.ROUNDS(16), .ROT(8), .KEY_ROT(8)) u_dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA.slave)
  );

  block_decryptor #(.ROUNDS(1), .ROT(8), .KEY_ROT(8)) u_dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB.slave)
  );

  int testsRun  = 0;
  int testsFail = 0;

  logic [127:0] expA[$];
  logic [127:0] expB[$];
  logic         prevDoneA = 1'b1;
  logic         prevDoneB = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
    int m;
    m = n % 128;
    if (m == 0) return x;
    return (x << m) | (x >> (128 - m));
  endfunction

  // Forward cipher of the 16-round encryptor, used to build round-trip vectors
  function automatic logic [127:0] encrypt(input logic [127:0] p, input logic [127:0] k);
    logic [127:0] s;
    s = p;
    for (int i = 0; i < 16; i++) s = rotl(s ^ rotl(k, (8 * i) % 128), 8);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic getDone(input bit sel);
    return sel ? ifB.o_done : ifA.o_done;
  endfunction

  function automatic logic getBusy(input bit sel);
    return sel ? ifB.o_busy : ifA.o_busy;
  endfunction

  function automatic logic [127:0] getPt(input bit sel);
    return sel ? ifB.o_plaintext : ifA.o_plaintext;
  endfunction

  task automatic applyStimulus(input bit sel, input logic st, input logic [127:0] ct, input logic [127:0] key);
    if (sel) begin
      ifB.i_start = st; ifB.i_ciphertext = ct; ifB.i_key = key;
    end else begin
      ifA.i_start = st; ifA.i_ciphertext = ct; ifA.i_key = key;
    end
  endtask

  // Issue one block, scramble the inputs after acceptance, optionally pulse
  // start again mid-run, then check busy length and that plaintext held still
  task automatic runBlock(input bit sel, input logic [127:0] ct, input logic [127:0] key,
                          input logic [127:0] exp, input int rounds, input string name,
                          input int midAt, input logic [127:0] midCt);
    logic [127:0] prevPt;
    int           busyCnt;
    bit           holdOk;
    bit           seenDone;
    @(negedge clk);
    applyStimulus(sel, 1'b1, ct, key);
    if (sel) expB.push_back(exp); else expA.push_back(exp);
    prevPt = getPt(sel);
    @(posedge clk);
    #1 applyStimulus(sel, 1'b0, rand128(), rand128());
    busyCnt  = 0;
    holdOk   = 1'b1;
    seenDone = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == midAt) applyStimulus(sel, 1'b1, midCt, rand128());
      else if (c == midAt + 1) applyStimulus(sel, 1'b0, midCt, rand128());
      if (getDone(sel)) begin
        seenDone = 1'b1;
        break;
      end
      if (getBusy(sel)) busyCnt++;
      if (getPt(sel) !== prevPt) holdOk = 1'b0;
    end
    applyStimulus(sel, 1'b0, '0, '0);
    checkOutput({name, "_timeout"}, 128'(!seenDone), 128'(0));
    checkOutput({name, "_busy_cycles"}, 128'(busyCnt), 128'(rounds));
    checkOutput({name, "_pt_hold"}, 128'(holdOk), 128'(1));
  endtask

  // Monitor for instance A: compare the result on every rising done
  always @(negedge clk) begin
    if (!rst && ifA.o_done && !prevDoneA) begin
      if (expA.size() == 0) checkOutput("A_unexpected_done", 128'(1), 128'(0));
      else checkOutput("A_plaintext", ifA.o_plaintext, expA.pop_front());
    end
    prevDoneA = ifA.o_done;
  end

  // Monitor for instance B: compare the result on every rising done
  always @(negedge clk) begin
    if (!rst && ifB.o_done && !prevDoneB) begin
      if (expB.size() == 0) checkOutput("B_unexpected_done", 128'(1), 128'(0));
      else checkOutput("B_plaintext", ifB.o_plaintext, expB.pop_front());
    end
    prevDoneB = ifB.o_done;
  end

  initial begin
    logic [128:0] dummy;
    logic [127:0] p;
    logic [127:0] k;
    bit           seen;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 128'h1407, '0);
    applyStimulus(1'b1, 1'b1, 128'h100, '0);

    // Reset holds the idle/reset outputs even with start high
    repeat (3) @(negedge clk);
    checkOutput("rst_done", 128'(ifA.o_done), 128'(1));
    checkOutput("rst_busy", 128'(ifA.o_busy), 128'(0));
    checkOutput("rst_pt", ifA.o_plaintext, 128'(0));
    checkOutput("rst_busyB", 128'(ifB.o_busy), 128'(0));
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_idle", 128'(ifA.o_busy), 128'(0));

    // Zero key: 16 rotates of 8 make the identity
    runBlock(1'b0, 128'h1407, '0, 128'h1407, 16, "zero_key", -1, '0);
    // Single-round instance
    runBlock(1'b1, 128'h100, '0, 128'h1, 1, "r1_a", -1, '0);
    runBlock(1'b1, 128'h0, 128'h1, 128'h1, 1, "r1_b", -1, '0);
    // All-ones key: 16 XORs with ~0 cancel
    runBlock(1'b0, 128'h11D, '1, 128'h11D, 16, "ones_key", -1, '0);
    // Second start mid-run is ignored
    runBlock(1'b0, 128'hCAFE, '0, 128'hCAFE, 16, "mid_start", 4, 128'hBEEF);

    // start held high: two back-to-back blocks with one done cycle between them
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 128'h77, '1);
    expA.push_back(128'h77);
    expA.push_back(128'h77);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ifA.o_done) begin seen = 1'b1; break; end
    end
    checkOutput("b2b_first_timeout", 128'(!seen), 128'(0));
    @(negedge clk);
    checkOutput("b2b_reaccept", 128'(ifA.o_busy), 128'(1));
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ifA.o_done) begin seen = 1'b1; break; end
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("b2b_second_timeout", 128'(!seen), 128'(0));

    // Reset in the middle of a block aborts it immediately
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 128'h1234, rand128());
    @(posedge clk);
    #1 applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_done", 128'(ifA.o_done), 128'(1));
    checkOutput("abort_busy", 128'(ifA.o_busy), 128'(0));
    checkOutput("abort_pt", ifA.o_plaintext, 128'(0));
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort_no_resume", 128'(ifA.o_busy), 128'(0));
    runBlock(1'b0, 128'h55, '1, 128'h55, 16, "after_abort", -1, '0);

    // Round trip against the encryptor model
    for (int n = 0; n < 20; n++) begin
      p = rand128();
      k = rand128();
      runBlock(1'b0, encrypt(p, k), k, p, 16, "roundtrip", -1, '0);
    end

    // Drain the scoreboards
    for (int c = 0; c < 50 && (expA.size() != 0 || expB.size() != 0); c++) @(negedge clk);
    checkOutput("queue_drain", 128'(expA.size() + expB.size()), 128'(0));
    dummy = '0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail + int'(dummy[0]));
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
